multiplier_pipelined: RTL and testbench

Parametrised, fully pipelined integer multiplier with valid/ready flow control, per-operation tag passthrough and optional signed mode. It supersedes the fixed 32×32 parallel multiplier as the functional-unit multiplier for the execute stage. It accepts one operation per cycle and returns products in issue order after a fixed latency, stalling the whole pipeline under output backpressure.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_stage.sv | 47 ++++
 rtl/multiplier_pipelined.sv | 91 +++++++++
 tb/tb_multiplier_pipelined.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants, stage control struct and chunk helper for the pipelined multiplier.
package mult_pkg;
  localparam int MULT_DEFAULT_WIDTH  = 32;
  localparam int MULT_DEFAULT_STAGES = 4;
  localparam int MULT_MAX_TAG_W      = 16;

  typedef struct packed {
    logic                      v;
    logic                      neg;
    logic [MULT_MAX_TAG_W-1:0] tag;
  } mult_stage_ctl_t;

  function automatic int mult_chunk(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction
endpackage

// File: rtl/mult_stage.sv
// One accumulate stage: multiplies a_mag by one chunk of b_mag, shifts it into place
// and adds it to the running product. Only the valid bit is reset.
module mult_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH,
  parameter int CHUNK = 8,
  parameter int SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  mult_stage_ctl_t    prev_ctl,
  input  logic [2*WIDTH-1:0] prev_acc,
  input  logic [WIDTH-1:0]   prev_a_mag,
  input  logic [WIDTH-1:0]   prev_b_mag,
  output mult_stage_ctl_t    ctl,
  output logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag
);
  logic [CHUNK-1:0]   b_chunk;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] chunk_ext;
  logic [2*WIDTH-1:0] partial;

  // The partial product is at most WIDTH+CHUNK bits and SHIFT <= WIDTH-CHUNK, so it never overflows 2*WIDTH.
  assign b_chunk   = prev_b_mag[SHIFT +: CHUNK];
  assign a_ext     = {{WIDTH{1'b0}}, prev_a_mag};
  assign chunk_ext = {{(2*WIDTH-CHUNK){1'b0}}, b_chunk};
  assign partial   = (a_ext * chunk_ext) << SHIFT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctl.v <= 1'b0;
    end else if (en) begin
      ctl.v <= prev_ctl.v;
    end
    if (en) begin
      ctl.neg <= prev_ctl.neg;
      ctl.tag <= prev_ctl.tag;
      acc     <= prev_acc + partial;
      a_mag   <= prev_a_mag;
      b_mag   <= prev_b_mag;
    end
  end
endmodule

// File: rtl/multiplier_pipelined.sv
// Fully pipelined WIDTH x WIDTH multiplier with valid/ready flow control and tag passthrough.
// Define MULT_SIGNED_EN to compile in per-operation two's-complement mode (signed_in).
module multiplier_pipelined
  import mult_pkg::*;
#(
  parameter int WIDTH  = MULT_DEFAULT_WIDTH,
  parameter int STAGES = MULT_DEFAULT_STAGES,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [2*WIDTH-1:0] r,
  output logic [TAG_W-1:0]   tag_out
);
  localparam int CHUNK = mult_chunk(WIDTH, STAGES);

  if ((STAGES < 1) || (WIDTH < 2) || (TAG_W < 1) || (TAG_W > MULT_MAX_TAG_W) ||
      ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_param_check
    $error("multiplier_pipelined: illegal WIDTH/STAGES/TAG_W combination");
  end

  mult_stage_ctl_t    ctl_p   [STAGES+1];
  logic [2*WIDTH-1:0] acc_p   [STAGES+1];
  logic [WIDTH-1:0]   a_mag_p [STAGES+1];
  logic [WIDTH-1:0]   b_mag_p [STAGES+1];
  logic               adv;
  logic               neg_in;
  logic [2*WIDTH-1:0] acc_out;

  // The whole pipeline advances together; a stalled result blocks new operands.
  assign adv      = !valid_out || ready_out;
  assign ready_in = adv;

`ifdef MULT_SIGNED_EN
  logic a_neg;
  logic b_neg;
  assign a_neg      = signed_in && a[WIDTH-1];
  assign b_neg      = signed_in && b[WIDTH-1];
  // Negating the most negative value wraps to 2^(WIDTH-1), which is its correct unsigned magnitude.
  assign a_mag_p[0] = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag_p[0] = b_neg ? (~b + WIDTH'(1)) : b;
  assign neg_in     = a_neg ^ b_neg;
  assign acc_out    = ctl_p[STAGES].neg ? (~acc_p[STAGES] + (2*WIDTH)'(1)) : acc_p[STAGES];
`else
  logic unused_signed;
  assign unused_signed = signed_in;
  assign a_mag_p[0]    = a;
  assign b_mag_p[0]    = b;
  assign neg_in        = 1'b0;
  assign acc_out       = acc_p[STAGES];
`endif

  assign ctl_p[0] = '{v: valid_in, neg: neg_in, tag: MULT_MAX_TAG_W'(tag_in)};
  assign acc_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .SHIFT(k * CHUNK)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (adv),
      .prev_ctl  (ctl_p[k]),
      .prev_acc  (acc_p[k]),
      .prev_a_mag(a_mag_p[k]),
      .prev_b_mag(b_mag_p[k]),
      .ctl       (ctl_p[k+1]),
      .acc       (acc_p[k+1]),
      .a_mag     (a_mag_p[k+1]),
      .b_mag     (b_mag_p[k+1])
    );
  end

  // Outputs read zero whenever no result is held, which also covers the reset state.
  assign valid_out = ctl_p[STAGES].v;
  assign r         = ctl_p[STAGES].v ? acc_out : '0;
  assign tag_out   = ctl_p[STAGES].v ? ctl_p[STAGES].tag[TAG_W-1:0] : '0;

  logic unused_tail;
  assign unused_tail = ^{a_mag_p[STAGES], b_mag_p[STAGES], ctl_p[STAGES].tag, ctl_p[STAGES].neg};
endmodule

// File: tb/tb_multiplier_pipelined.sv
// Directed bench for multiplier_pipelined (WIDTH=32, STAGES=4, TAG_W=4).
module tb_multiplier_pipelined;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_in;
  logic [3:0]  tag_in;
  logic        valid_out;
  logic        ready_out;
  logic [63:0] r;
  logic [3:0]  tag_out;

  multiplier_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .a(a), .b(b), .signed_in(signed_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .r(r), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops = 0;
  int          pushes = 0;
  int          first_vo = -1;
  int          gaps = 0;
  int          track_total = 0;
  bit          track = 1'b0;
  bit          last_accept = 1'b0;
  logic [63:0] cur_exp;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Scores the current output, records the current input if accepted, then crosses one edge.
  task automatic tick();
    exp_t e;
    #1;
    if (reset_n && valid_out && ready_out) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_result observed=0x%0h expected=none", r);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result_r", r, e.r);
        chk("result_tag", 64'(tag_out), 64'(e.tag));
        pops++;
      end
    end
    last_accept = reset_n && valid_in && ready_in;
    if (last_accept) begin
      exp_q.push_back('{r: cur_exp, tag: tag_in});
      pushes++;
    end
    if (!reset_n) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (track) begin
      if (valid_out && first_vo < 0) first_vo = cyc;
      if (first_vo >= 0 && !valid_out && pops < track_total) gaps++;
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [3:0] it, input logic [63:0] ie);
    a = ia; b = ib; signed_in = is; tag_in = it; cur_exp = ie; valid_in = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_left_in_queue"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_valid_after"}, 64'(valid_out), 64'd0);
  endtask

  logic [63:0] bp_exp [4] = '{64'd10, 64'd22, 64'd36, 64'd52};
  logic [63:0] snap_r;
  logic [3:0]  snap_tag;
  logic [31:0] sa;
  logic [31:0] sb;
  logic [7:0]  pat;
  int          acc0;
  int          n;

  initial begin
    reset_n = 1'b0; valid_in = 1'b1; a = 32'd5; b = 32'd7; signed_in = 1'b0;
    tag_in = 4'd3; ready_out = 1'b1; cur_exp = 64'd35;

    // Reset held with a valid operand present
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_r", r, 64'd0);
      chk("rst_tag_out", 64'(tag_out), 64'd0);
    end
    reset_n = 1'b1; valid_in = 1'b0;
    #1;
    chk("ready_in_after_reset", 64'(ready_in), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_result_after_reset", 64'(valid_out), 64'd0);
    end

    // Directed vectors, back to back
    issue(32'd3, 32'd5, 1'b0, 4'd1, 64'd15);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2, 64'hFFFF_FFFE_0000_0001);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd3, 64'h4000_0000_0000_0000);
`ifdef MULT_SIGNED_EN
    issue(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    issue(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd4, 64'h0000_0001_FFFF_FFFE);
`endif
    issue(32'hFFFF_FFFF, 32'd2, 1'b0, 4'd5, 64'h0000_0001_FFFF_FFFE);
`ifdef MULT_SIGNED_EN
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32'h8000_0000, 32'd1, 1'b1, 4'd8, 64'hFFFF_FFFF_8000_0000);
`else
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 4'd6, 64'h0000_0004_FFFF_FFF1);
    issue(32'h8000_0000, 32'd1, 1'b1, 4'd8, 64'h0000_0000_8000_0000);
`endif
    issue(32'd0, 32'hFFFF_FFFF, 1'b1, 4'd7, 64'd0);
    drain("directed");

    // Streaming: 100 back-to-back operations
    pops = 0; pushes = 0; first_vo = -1; gaps = 0; track_total = 100; track = 1'b1;
    sa = 32'd0; sb = 32'd0; acc0 = cyc;
    for (int i = 0; i < 100; i++) begin
      issue(sa, sb, 1'b0, 4'(i % 16), {32'd0, sa} * {32'd0, sb});
      sa = sa + 32'h2345_6789;
      sb = sb + 32'h3456_7891;
    end
    drain("stream");
    track = 1'b0;
    chk("stream_latency", 64'(first_vo - acc0), 64'(STAGES));
    chk("stream_gaps", 64'(gaps), 64'd0);
    chk("stream_count", 64'(pops), 64'd100);

    // Backpressure: fill, stall 5 cycles, release
    pops = 0; pushes = 0;
    for (int j = 0; j < 4; j++) issue(32'(j + 1), 32'(j + 10), 1'b0, 4'(j), bp_exp[j]);
    chk("bp_full_valid", 64'(valid_out), 64'd1);
    a = 32'd100; b = 32'd200; tag_in = 4'hA; cur_exp = 64'd20000; valid_in = 1'b1;
    ready_out = 1'b0;
    #1;
    snap_r = r; snap_tag = tag_out;
    chk("bp_first_r", snap_r, 64'd10);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready_in", 64'(ready_in), 64'd0);
      tick();
      chk("bp_r_frozen", r, snap_r);
      chk("bp_tag_frozen", 64'(tag_out), 64'(snap_tag));
      chk("bp_valid_held", 64'(valid_out), 64'd1);
    end
    ready_out = 1'b1;
    tick();
    issue(32'h0000_FFFF, 32'h0001_0000, 1'b0, 4'hB, 64'h0000_0000_FFFF_0000);
    issue(32'h1234_5678, 32'h0000_0010, 1'b0, 4'hC, 64'h0000_0001_2345_6780);
    drain("bp");
    chk("bp_count", 64'(pops), 64'd7);

    // Irregular ready_out pattern, producer holds until accepted
    pops = 0; pat = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i + 2); b = 32'd3; signed_in = 1'b0; tag_in = 4'(i + 1);
      cur_exp = 64'((i + 2) * 3); valid_in = 1'b1;
      n = 0;
      do begin
        ready_out = pat[cyc % 8];
        tick();
        n++;
      end while (!last_accept && n < 20);
      chk("toggle_accepted", 64'(last_accept), 64'd1);
    end
    drain("toggle");
    chk("toggle_count", 64'(pops), 64'd8);

    // Reset while three operations are in flight
    issue(32'd11, 32'd13, 1'b0, 4'd1, 64'd143);
    issue(32'd17, 32'd19, 1'b0, 4'd2, 64'd323);
    issue(32'd23, 32'd29, 1'b0, 4'd3, 64'd667);
    chk("mid_no_result_yet", 64'(valid_out), 64'd0);
    valid_in = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_flushed", 64'(valid_out), 64'd0);
    end
    acc0 = cyc;
    issue(32'd7, 32'd9, 1'b0, 4'd5, 64'd63);
    valid_in = 1'b0;
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    chk("mid_latency", 64'(cyc - acc0), 64'(STAGES));
    chk("mid_r", r, 64'd63);
    drain("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
